scanline_fetch: RTL and testbench

- Upstream feeder for the VGA video output stage.
- Prefetches the next 320-pixel logical row from VRAM into a ping-pong line buffer, one byte per handshake, while the current row is being displayed.
- Once per 8-phase pixel cycle, presents the even/odd logical pixel pair (pixel1/pixel2) addressed by the output stage's xCoord/yCoord.

---
 rtl/scanline_fetch.sv | 137 +++++++++++++
 tb/tb_scanline_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_fetch.sv
// Prefetches the next logical row from VRAM into a ping-pong line buffer and
// presents the even/odd pixel pair addressed by the output stage each pixel cycle.
module scanline_fetch #(
  parameter int         LINE_PIXELS  = 320,
  parameter int         VISIBLE_ROWS = 240,
  parameter int         LAST_ROW     = 262,
  parameter logic [2:0] LOAD_PHASE   = 3'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  clockPhase,
  input  logic [8:0]  xCoord,
  input  logic [8:0]  yCoord,     // 9 bits so blanking rows up to LAST_ROW are representable
  input  logic [16:0] frameBase,
  output logic        vramReq,
  output logic [16:0] vramAddr,
  input  logic        vramAck,
  input  logic [7:0]  vramData,
  output logic [7:0]  pixel1,
  output logic [7:0]  pixel2,
  output logic        underrun,
  output logic        debug_state
);

  localparam int WORDS = LINE_PIXELS / 2;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t      state;
  logic        front;
  logic        front_valid;
  logic        back_valid;
  logic [8:0]  y_prev;
  logic [8:0]  col;
  logic [16:0] base;
  logic [7:0]  held;
  logic [15:0] line_mem [0:1][0:WORDS-1];
  logic [15:0] rd_word;
  logic        rd_ok;

  logic        row_change;
  logic [9:0]  y_next;
  logic        wrap;
  logic        has_target;
  logic [8:0]  target_row;
  logic [16:0] start_base;
  logic [16:0] row_base;
  logic        beat;
  logic        last_col;
  logic        in_range;
  logic [7:0]  rd_idx;

  assign debug_state = state;

  always_comb begin
    row_change = (yCoord != y_prev);
    y_next     = {1'b0, yCoord} + 10'd1;
    wrap       = (yCoord == 9'(LAST_ROW));
    has_target = wrap || (y_next < 10'(VISIBLE_ROWS));
    target_row = wrap ? 9'd0 : y_next[8:0];
    start_base = wrap ? frameBase : base;
    // row * 320 as (row << 8) + (row << 6), wrapping at 17 bits
    row_base   = start_base + {target_row, 8'd0} + {2'b00, target_row, 6'd0};
    // an ack coinciding with a row change belongs to the aborted fetch
    beat       = (state == FETCH) && vramReq && vramAck && !row_change;
    last_col   = (col == 9'(LINE_PIXELS - 1));
    in_range   = (xCoord < 9'(LINE_PIXELS));
    rd_idx     = in_range ? xCoord[8:1] : 8'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      front       <= 1'b0;
      front_valid <= 1'b0;
      back_valid  <= 1'b0;
      y_prev      <= 9'd0;
      col         <= 9'd0;
      base        <= 17'd0;
      held        <= 8'd0;
      vramReq     <= 1'b0;
      vramAddr    <= 17'd0;
      underrun    <= 1'b0;
    end else begin
      y_prev <= yCoord;
      if (row_change) begin
        front       <= ~front;
        front_valid <= back_valid && (state != FETCH);
        back_valid  <= 1'b0;
        vramReq     <= 1'b0;
        if (state == FETCH) underrun <= 1'b1;
        if (has_target) begin
          state    <= FETCH;
          col      <= 9'd0;
          vramAddr <= row_base;
          if (wrap) base <= frameBase;
        end else begin
          state <= IDLE;
        end
      end else if (state == FETCH) begin
        if (beat) begin
          col      <= col + 9'd1;
          vramAddr <= vramAddr + 17'd1;
          if (!col[0]) held <= vramData;
          if (last_col) begin
            vramReq    <= 1'b0;
            back_valid <= 1'b1;
            state      <= IDLE;
          end
        end else begin
          vramReq <= 1'b1;
        end
      end
    end
  end

  // Line buffer: the fetch writes the back bank, the readout reads the front bank.
  always_ff @(posedge clock) begin
    if (beat && col[0]) line_mem[~front][col[8:1]] <= {vramData, held};
    if (clockPhase == LOAD_PHASE) rd_word <= line_mem[front][rd_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ok  <= 1'b0;
      pixel1 <= 8'd0;
      pixel2 <= 8'd0;
    end else begin
      if (clockPhase == LOAD_PHASE) rd_ok <= in_range;
      if (clockPhase == LOAD_PHASE + 3'd1) begin
        pixel1 <= (rd_ok && front_valid) ? rd_word[7:0]  : 8'd0;
        pixel2 <= (rd_ok && front_valid) ? rd_word[15:8] : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_scanline_fetch.sv
// Directed bench for scanline_fetch: a VRAM model returning the low address byte,
// row fetch/abort sequences and pixel readout checks.
module tb_scanline_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  clockPhase;
  logic [8:0]  xCoord;
  logic [8:0]  yCoord;
  logic [16:0] frameBase;
  logic        vramReq;
  logic [16:0] vramAddr;
  logic        vramAck = 1'b0;
  logic [7:0]  vramData = 8'd0;
  logic [7:0]  pixel1;
  logic [7:0]  pixel2;
  logic        underrun;
  logic        debug_state;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cnt = 0;
  int beats_total = 0;
  int b0;
  logic [16:0] last_addr = 17'd0;

  scanline_fetch dut (
    .clock(clock), .reset(reset), .clockPhase(clockPhase), .xCoord(xCoord),
    .yCoord(yCoord), .frameBase(frameBase), .vramReq(vramReq), .vramAddr(vramAddr),
    .vramAck(vramAck), .vramData(vramData), .pixel1(pixel1), .pixel2(pixel2),
    .underrun(underrun), .debug_state(debug_state)
  );

  always #5 clock = ~clock;

  // VRAM model: ack after lat idle clocks, data = low byte of the address
  always @(negedge clock) begin
    if (reset && vramReq) begin
      if (cnt >= lat) begin
        vramAck  = 1'b1;
        vramData = vramAddr[7:0];
        cnt      = 0;
      end else begin
        vramAck = 1'b0;
        cnt++;
      end
    end else begin
      vramAck = 1'b0;
      cnt     = 0;
    end
  end

  always @(posedge clock) begin
    if (reset && vramReq && vramAck) begin
      beats_total++;
      last_addr = vramAddr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    clockPhase = clockPhase + 3'd1;
  endtask

  task automatic run_to_phase(input logic [2:0] p);
    do cyc(); while (clockPhase != p);
  endtask

  task automatic show(input logic [8:0] x);
    xCoord = x;
    run_to_phase(3'd1);
    run_to_phase(3'd2);
  endtask

  task automatic check_px(input string tag, input logic [7:0] p1, input logic [7:0] p2);
    check({tag, "_px1"}, pixel1, p1);
    check({tag, "_px2"}, pixel2, p2);
  endtask

  task automatic wait_req(input string tag, input logic [16:0] exp_addr);
    int n;
    n = 0;
    while (!vramReq && n < 50) begin
      cyc();
      n++;
    end
    check({tag, "_req"}, vramReq, 1);
    check({tag, "_addr"}, vramAddr, exp_addr);
  endtask

  task automatic wait_done(input string tag, input int start, input int limit);
    int n;
    n = 0;
    while (!((beats_total - start) >= 320 && !vramReq) && n < limit) begin
      cyc();
      n++;
    end
    check({tag, "_beats"}, beats_total - start, 320);
    check({tag, "_req_low"}, vramReq, 0);
  endtask

  task automatic no_req(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      cyc();
      if (vramReq) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    reset      = 1'b0;
    clockPhase = 3'd0;
    xCoord     = 9'd0;
    yCoord     = 9'd0;
    frameBase  = 17'h01000;
    repeat (3) cyc();
    check("rst_req", vramReq, 0);
    check("rst_addr", vramAddr, 0);
    check_px("rst", 8'h00, 8'h00);
    check("rst_underrun", underrun, 0);
    check("rst_state", debug_state, 0);
    reset = 1'b1;

    no_req("idle_after_reset", 20);
    yCoord = 9'd240;
    no_req("row240_no_fetch", 20);
    yCoord = 9'd261;
    no_req("row261_no_fetch", 20);
    show(9'd4);
    check_px("first_frame", 8'h00, 8'h00);

    // frame wrap: row 0 fetched during row 262 from the latched frameBase
    yCoord = 9'd262;
    wait_req("row0", 17'h01000);
    b0 = beats_total;
    frameBase = 17'h00000;
    wait_done("row0", b0, 2000);
    check("row0_last_addr", last_addr, 17'h0113F);
    show(9'd4);
    check_px("row262_blank", 8'h00, 8'h00);

    yCoord = 9'd0;
    wait_req("row1", 17'h01140);
    b0 = beats_total;
    show(9'd4);
    check_px("row0_x4", 8'h04, 8'h05);
    xCoord = 9'd319;
    run_to_phase(3'd1);
    check_px("x319_hold", 8'h04, 8'h05);
    run_to_phase(3'd2);
    check_px("x319", 8'h3E, 8'h3F);
    show(9'd320);
    check_px("x320", 8'h00, 8'h00);
    show(9'd0);
    check_px("row0_x0", 8'h00, 8'h01);
    check("no_underrun_a", underrun, 0);
    wait_done("row1", b0, 2000);

    yCoord = 9'd262;
    wait_req("row0b", 17'h00000);
    b0 = beats_total;
    wait_done("row0b", b0, 2000);

    yCoord = 9'd5;
    wait_req("row6", 17'h00780);
    b0 = beats_total;
    wait_done("row6", b0, 2000);

    yCoord = 9'd6;
    wait_req("row7", 17'h008C0);
    b0 = beats_total;
    show(9'd4);
    check_px("row6_x4", 8'h84, 8'h85);
    wait_done("row7", b0, 2000);

    // slow VRAM: the row-8 fetch cannot finish before the next row change
    lat = 20;
    yCoord = 9'd7;
    wait_req("row8", 17'h00A00);
    show(9'd4);
    check_px("row7_x4", 8'hC4, 8'hC5);
    check("no_underrun_b", underrun, 0);
    repeat (200) cyc();
    check("row8_busy", vramReq, 1);
    yCoord = 9'd8;
    cyc();
    check("abort_underrun", underrun, 1);
    check("abort_req_drop", vramReq, 0);
    lat = 1;
    wait_req("row9", 17'h00B40);
    b0 = beats_total;
    show(9'd4);
    check_px("abort_row", 8'h00, 8'h00);
    check("underrun_sticky", underrun, 1);
    wait_done("row9", b0, 3000);

    yCoord = 9'd9;
    wait_req("row10", 17'h00C80);
    b0 = beats_total;
    show(9'd4);
    check_px("row9_x4", 8'h44, 8'h45);
    begin
      int n;
      n = 0;
      while ((beats_total - b0) < 100 && n < 1000) begin
        cyc();
        n++;
      end
    end
    check("col100_reached", ((beats_total - b0) >= 100), 1);
    check("pre_reset_req", vramReq, 1);

    // asynchronous reset between clock edges
    #2 reset = 1'b0;
    #1;
    check("async_rst_req", vramReq, 0);
    check_px("async_rst", 8'h00, 8'h00);
    check("async_rst_underrun", underrun, 0);
    check("async_rst_addr", vramAddr, 0);
    yCoord = 9'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    no_req("post_reset_idle", 30);
    yCoord = 9'd1;
    begin
      int n;
      n = 0;
      while (!vramReq && n < 50) begin
        cyc();
        n++;
      end
    end
    check("post_reset_fetch", vramReq, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
